// File: rtl/asg_burst_ch_if.sv
// Configuration, table-write and status bundle between the bus register wrapper
// and one asg_burst_ch channel core.
interface asg_burst_ch_if #(
    parameter int DW  = 14,
    parameter int RSZ = 14,
    parameter int FW  = 16,
    parameter int CW  = 16,
    parameter int DLW = 32
);
    logic        [RSZ+FW-1:0] tbl_size_i;
    logic        [RSZ+FW-1:0] step_i;
    logic        [RSZ+FW-1:0] ofs_i;
    logic        [DW-1:0]     amp_i;
    logic signed [DW-1:0]     dc_i;
    logic                     burst_i;
    logic        [CW-1:0]     ncyc_i;
    logic        [CW-1:0]     nrep_i;
    logic        [DLW-1:0]    rdly_i;
    logic                     trig_i;
    logic                     start_i;
    logic                     stop_i;
    logic                     wr_en_i;
    logic        [RSZ-1:0]    wr_addr_i;
    logic signed [DW-1:0]     wr_data_i;
    logic signed [DW-1:0]     dac_o;
    logic        [RSZ+FW-1:0] ptr_o;
    logic                     busy_o;
    logic                     trig_o;
    logic                     done_o;

    modport master (
        output tbl_size_i, step_i, ofs_i, amp_i, dc_i, burst_i, ncyc_i, nrep_i,
               rdly_i, trig_i, start_i, stop_i, wr_en_i, wr_addr_i, wr_data_i,
        input  dac_o, ptr_o, busy_o, trig_o, done_o
    );

    modport slave (
        input  tbl_size_i, step_i, ofs_i, amp_i, dc_i, burst_i, ncyc_i, nrep_i,
               rdly_i, trig_i, start_i, stop_i, wr_en_i, wr_addr_i, wr_data_i,
        output dac_o, ptr_o, busy_o, trig_o, done_o
    );
endinterface

// File: rtl/asg_burst_ch.sv
// Single-channel arbitrary signal generator: fractional table pointer, burst
// sequencer (cycles/repetitions/delay/abort) and a 3-stage gain/offset pipeline.
module asg_burst_ch #(
    parameter int DW  = 14,
    parameter int RSZ = 14,
    parameter int FW  = 16,
    parameter int CW  = 16,
    parameter int DLW = 32
) (
    input logic           dac_clk_i,
    input logic           dac_rst_i,
    asg_burst_ch_if.slave bus
);
    localparam int PW = RSZ + FW;

    typedef enum logic [1:0] {IDLE, RUN, DELAY} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       ptr, ptr_nxt;
    logic [CW-1:0]       cyc, cyc_nxt;
    logic [CW-1:0]       rep, rep_nxt;
    logic [DLW-1:0]      dly, dly_nxt;
    logic                trig_q;
    logic                trig_evt;
    logic                trig_r, trig_nxt;
    logic                done_r, done_nxt;

    logic [PW:0]         ptr_inc;
    logic [PW-1:0]       ptr_wrap;
    logic                wrap;
    logic [CW-1:0]       ncyc_eff;
    logic [CW-1:0]       cyc_inc;
    logic [CW-1:0]       rep_inc;
    logic                burst_end;
    logic                last_rep;
    logic                dly_last;

    logic signed [DW-1:0] mem [0:(1<<RSZ)-1];
    logic signed [DW-1:0] rd_p0;
    logic                 vld_p0;
    logic signed [DW+1:0] prod_p1;
    logic                 vld_p1;
    logic signed [DW-1:0] dac_p2;

    // Signed sample times unsigned gain, gain of 2**(DW-1) is unity.
    function automatic logic signed [DW+1:0] scale(input logic signed [DW-1:0] s,
                                                   input logic        [DW-1:0] a);
        logic signed [2*DW:0] p;
        p = $signed({{(DW+1){s[DW-1]}}, s}) * $signed({{(DW+1){1'b0}}, a});
        return (DW+2)'(p >>> (DW-1));
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v,
                                                 input logic signed [DW-1:0] d);
        logic signed [DW+2:0] s;
        s = {v[DW+1], v} + {{3{d[DW-1]}}, d};
        if (s[DW+2:DW-1] == {4{s[DW+2]}})
            return s[DW-1:0];
        else if (s[DW+2])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    assign trig_evt  = bus.start_i | (bus.trig_i & ~trig_q);
    assign ptr_inc   = {1'b0, ptr} + {1'b0, bus.step_i};
    assign wrap      = ptr_inc > {1'b0, bus.tbl_size_i};
    // Only used when wrapping, so the true result always fits in PW bits.
    assign ptr_wrap  = ptr_inc[PW-1:0] - bus.tbl_size_i - PW'(1);
    assign ncyc_eff  = (bus.ncyc_i == '0) ? CW'(1) : bus.ncyc_i;
    assign cyc_inc   = cyc + CW'(1);
    assign rep_inc   = rep + CW'(1);
    assign burst_end = bus.burst_i && (cyc_inc >= ncyc_eff);
    assign last_rep  = (bus.nrep_i != '0) && (rep_inc >= bus.nrep_i);
    assign dly_last  = ({1'b0, dly} + (DLW+1)'(1)) >= {1'b0, bus.rdly_i};

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state  <= IDLE;
            ptr    <= '0;
            cyc    <= '0;
            rep    <= '0;
            dly    <= '0;
            trig_q <= 1'b0;
            trig_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cyc    <= cyc_nxt;
            rep    <= rep_nxt;
            dly    <= dly_nxt;
            trig_q <= bus.trig_i;
            trig_r <= trig_nxt;
            done_r <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cyc_nxt   = cyc;
        rep_nxt   = rep;
        dly_nxt   = dly;
        trig_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (bus.stop_i) begin
            state_nxt = IDLE;
            ptr_nxt   = bus.ofs_i;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig_evt) begin
                        state_nxt = RUN;
                        ptr_nxt   = bus.ofs_i;
                        cyc_nxt   = '0;
                        rep_nxt   = '0;
                        trig_nxt  = 1'b1;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        ptr_nxt = ptr_wrap;
                        if (burst_end) begin
                            cyc_nxt = '0;
                            rep_nxt = rep_inc;
                            if (last_rep) begin
                                state_nxt = IDLE;
                                ptr_nxt   = bus.ofs_i;
                                done_nxt  = 1'b1;
                            end else if (bus.rdly_i == '0) begin
                                ptr_nxt  = bus.ofs_i;
                                trig_nxt = 1'b1;
                            end else begin
                                state_nxt = DELAY;
                                dly_nxt   = '0;
                            end
                        end else begin
                            cyc_nxt = cyc_inc;
                        end
                    end else begin
                        ptr_nxt = ptr_inc[PW-1:0];
                    end
                end
                DELAY: begin
                    if (dly_last) begin
                        state_nxt = RUN;
                        ptr_nxt   = bus.ofs_i;
                        trig_nxt  = 1'b1;
                    end else begin
                        dly_nxt = dly + DLW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Table write port; a same-address read in this clock still sees old data.
    always_ff @(posedge dac_clk_i) begin
        if (bus.wr_en_i)
            mem[bus.wr_addr_i] <= bus.wr_data_i;
    end

    // Stage p0: table read; valid marks samples taken while running.
    always_ff @(posedge dac_clk_i) begin
        rd_p0 <= mem[ptr[PW-1:FW]];
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= (state == RUN);
            vld_p1 <= vld_p0;
        end
    end

    // Stage p1: gain.
    always_ff @(posedge dac_clk_i) begin
        prod_p1 <= scale(rd_p0, bus.amp_i);
    end

    // Stage p2: offset and saturation; idle samples contribute zero.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i)
            dac_p2 <= '0;
        else
            dac_p2 <= sat(vld_p1 ? prod_p1 : '0, bus.dc_i);
    end

    assign bus.dac_o  = dac_p2;
    assign bus.ptr_o  = ptr;
    assign bus.busy_o = (state != IDLE);
    assign bus.trig_o = trig_r;
    assign bus.done_o = done_r;
endmodule

// File: tb/tb_asg_burst_ch.sv
// Bench for asg_burst_ch: burst-level reference model of pointer/status plus
// arithmetic model of the gain/offset path, directed and random scenarios.
module tb_asg_burst_ch;
    localparam int DW  = 14;
    localparam int RSZ = 14;
    localparam int FW  = 16;
    localparam int CW  = 16;
    localparam int DLW = 32;
    localparam int PW  = RSZ + FW;
    localparam int NT  = 16;
    localparam int SMAX = (1 << (DW - 1)) - 1;
    localparam int SMIN = -(1 << (DW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    asg_burst_ch_if #(.DW(DW), .RSZ(RSZ), .FW(FW), .CW(CW), .DLW(DLW)) bus ();

    asg_burst_ch #(.DW(DW), .RSZ(RSZ), .FW(FW), .CW(CW), .DLW(DLW)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tbl_m [NT];
    longint c_tbl, c_step, c_ofs;
    int c_amp, c_dc, c_ncyc, c_nrep, c_rdly;
    bit c_burst;
    longint m_ptr [$];
    bit m_busy [$], m_trig [$], m_done [$], m_act [$];
    int seen_trig, seen_done;

    function automatic void push(longint p, bit b, bit t, bit d, bit a);
        m_ptr.push_back(p);
        m_busy.push_back(b);
        m_trig.push_back(t);
        m_done.push_back(d);
        m_act.push_back(a);
    endfunction

    // Expected per-cycle status, cycle 0 being the first cycle after the trigger.
    function automatic void build_model(int n);
        longint p;
        int cyc;
        int nc;
        nc = (c_ncyc == 0) ? 1 : c_ncyc;
        m_ptr.delete(); m_busy.delete(); m_trig.delete(); m_done.delete(); m_act.delete();
        for (int r = 0; m_ptr.size() < n; r++) begin
            p = c_ofs;
            cyc = 0;
            for (int k = 0; m_ptr.size() < n; k++) begin
                push(p, 1'b1, k == 0, 1'b0, 1'b1);
                p = p + c_step;
                if (p > c_tbl) begin
                    p = p - (c_tbl + 1);
                    cyc++;
                    if (c_burst && cyc == nc) break;
                end
            end
            if (m_ptr.size() >= n) break;
            if (c_nrep != 0 && r + 1 == c_nrep) begin
                push(c_ofs, 1'b0, 1'b0, 1'b1, 1'b0);
                while (m_ptr.size() < n) push(c_ofs, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                for (int d = 0; d < c_rdly && m_ptr.size() < n; d++)
                    push(p, 1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
    endfunction

    function automatic int exp_dac(int k);
        longint v;
        v = 0;
        if (k >= 3 && m_act[k-3])
            v = (longint'(tbl_m[int'(m_ptr[k-3] >> FW)]) * c_amp) >>> (DW - 1);
        v = v + c_dc;
        if (v > SMAX) v = SMAX;
        if (v < SMIN) v = SMIN;
        return int'(v);
    endfunction

    function automatic int sat_dc();
        return (c_dc > SMAX) ? SMAX : (c_dc < SMIN) ? SMIN : c_dc;
    endfunction

    task automatic apply_cfg();
        bus.tbl_size_i = PW'(c_tbl);
        bus.step_i     = PW'(c_step);
        bus.ofs_i      = PW'(c_ofs);
        bus.amp_i      = DW'(c_amp);
        bus.dc_i       = DW'(c_dc);
        bus.burst_i    = c_burst;
        bus.ncyc_i     = CW'(c_ncyc);
        bus.nrep_i     = CW'(c_nrep);
        bus.rdly_i     = DLW'(c_rdly);
    endtask

    task automatic wr_tbl(int a, int d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = RSZ'(a);
        bus.wr_data_i = DW'(d);
        tbl_m[a]      = d;
        @(negedge clk);
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic settle();
        apply_cfg();
        repeat (4) @(negedge clk);
    endtask

    task automatic kick(bit use_trig);
        seen_trig = 0;
        seen_done = 0;
        if (use_trig) bus.trig_i = 1'b1;
        else bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic finish_run();
        bus.trig_i = 1'b0;
        bus.stop_i = 1'b1;
        @(negedge clk);
        bus.stop_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_window(string nm, int n);
        int e;
        build_model(n);
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (longint'(bus.ptr_o) !== m_ptr[k]) begin
                n_fail++;
                $display("FAIL %s ptr cyc %0d got %0h want %0h", nm, k, bus.ptr_o, m_ptr[k]);
            end
            n_checks++;
            if (bus.busy_o !== m_busy[k]) begin
                n_fail++;
                $display("FAIL %s busy cyc %0d got %b want %b", nm, k, bus.busy_o, m_busy[k]);
            end
            n_checks++;
            if (bus.trig_o !== m_trig[k]) begin
                n_fail++;
                $display("FAIL %s trig cyc %0d got %b want %b", nm, k, bus.trig_o, m_trig[k]);
            end
            n_checks++;
            if (bus.done_o !== m_done[k]) begin
                n_fail++;
                $display("FAIL %s done cyc %0d got %b want %b", nm, k, bus.done_o, m_done[k]);
            end
            e = exp_dac(k);
            n_checks++;
            if (int'($signed(bus.dac_o)) !== e) begin
                n_fail++;
                $display("FAIL %s dac cyc %0d got %0d want %0d", nm, k, $signed(bus.dac_o), e);
            end
            if (bus.trig_o === 1'b1) seen_trig++;
            if (bus.done_o === 1'b1) seen_done++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(string nm, int want_dac, longint want_ptr);
        n_checks++;
        if (int'($signed(bus.dac_o)) !== want_dac) begin
            n_fail++; $display("FAIL %s dac got %0d want %0d", nm, $signed(bus.dac_o), want_dac);
        end
        n_checks++;
        if (longint'(bus.ptr_o) !== want_ptr) begin
            n_fail++; $display("FAIL %s ptr got %0h want %0h", nm, bus.ptr_o, want_ptr);
        end
        n_checks++;
        if ({bus.busy_o, bus.trig_o, bus.done_o} !== 3'b000) begin
            n_fail++; $display("FAIL %s busy/trig/done got %b want 000", nm, {bus.busy_o, bus.trig_o, bus.done_o});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 0, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < NT; k++) wr_tbl(k, (k < 8) ? k : int'($urandom_range(0, 16383)) - 8192);
    endtask

    task automatic test_continuous();
        load_ramp();
        c_tbl = (8 << FW) - 1; c_step = 1 << FW; c_ofs = 0;
        c_amp = 'h2000; c_dc = 0; c_burst = 0; c_ncyc = 0; c_nrep = 0; c_rdly = 0;
        settle();
        kick(0);
        check_window("cont_step1", 40);
        finish_run();
        c_step = 'h18000;
        settle();
        kick(0);
        check_window("cont_frac", 40);
        finish_run();
        c_tbl = 7 << FW; c_step = 1 << FW; c_dc = -21;
        settle();
        kick(0);
        check_window("cont_tbl7", 40);
        finish_run();
    endtask

    task automatic sat_case(string nm, int tv, int amp, int dc, int want);
        wr_tbl(0, tv);
        c_tbl = (8 << FW) - 1; c_step = 0; c_ofs = 0; c_amp = amp; c_dc = dc;
        c_burst = 0; c_ncyc = 0; c_nrep = 0; c_rdly = 0;
        settle();
        n_checks++;
        if (int'($signed(bus.dac_o)) !== dc) begin
            n_fail++; $display("FAIL %s idle dac got %0d want %0d", nm, $signed(bus.dac_o), dc);
        end
        kick(0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (int'($signed(bus.dac_o)) !== want) begin
            n_fail++; $display("FAIL %s dac got %0d want %0d", nm, $signed(bus.dac_o), want);
        end
        finish_run();
    endtask

    task automatic test_saturation();
        sat_case("sat_pos", 8191, 'h2000, 1000, 8191);
        sat_case("sat_neg", -8192, 'h2000, -500, -8192);
        sat_case("half_gain", 8000, 'h1000, 0, 4000);
    endtask

    task automatic test_burst();
        load_ramp();
        c_tbl = (8 << FW) - 1; c_step = 1 << FW; c_ofs = 0; c_amp = 'h2000; c_dc = -37;
        c_burst = 1; c_ncyc = 2; c_nrep = 3; c_rdly = 5;
        settle();
        kick(1);
        check_window("burst", 75);
        n_checks++;
        if (seen_trig !== 3) begin
            n_fail++; $display("FAIL burst trig_count got %0d want 3", seen_trig);
        end
        n_checks++;
        if (seen_done !== 1) begin
            n_fail++; $display("FAIL burst done_count got %0d want 1", seen_done);
        end
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL burst final_busy got %b want 0", bus.busy_o);
        end
        finish_run();
    endtask

    task automatic test_back_to_back();
        c_tbl = (4 << FW) - 1; c_step = 1 << FW; c_ofs = 1 << FW; c_amp = 'h3000; c_dc = 55;
        c_burst = 1; c_ncyc = 0; c_nrep = 2; c_rdly = 0;
        settle();
        kick(0);
        check_window("back_to_back", 20);
        finish_run();
    endtask

    task automatic test_stop();
        c_tbl = (8 << FW) - 1; c_step = 1 << FW; c_ofs = 3 << FW; c_amp = 'h2000; c_dc = 7;
        c_burst = 1; c_ncyc = 1; c_nrep = 0; c_rdly = 8;
        settle();
        kick(0);
        check_window("stop_pre", 9);
        bus.stop_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.stop_i = 1'b0;
        bus.start_i = 1'b0;
        check_idle_outputs("stop_abort", 7, c_ofs);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.busy_o, bus.done_o} !== 2'b00) begin
                n_fail++; $display("FAIL stop_after busy/done got %b want 00", {bus.busy_o, bus.done_o});
            end
        end
        c_ofs = 5 << FW;
        settle();
        kick(0);
        check_window("stop_restart", 30);
        finish_run();
    endtask

    task automatic test_rst_mid_run();
        load_ramp();
        c_tbl = (8 << FW) - 1; c_step = 1 << FW; c_ofs = 0; c_amp = 'h2000; c_dc = 123;
        c_burst = 0; c_ncyc = 0; c_nrep = 0; c_rdly = 0;
        settle();
        kick(0);
        check_window("pre_rst", 10);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_rst", 0, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (int'($signed(bus.dac_o)) !== 123) begin
            n_fail++; $display("FAIL post_rst_idle dac got %0d want 123", $signed(bus.dac_o));
        end
        kick(0);
        check_window("post_rst", 30);
        finish_run();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NT; k++) wr_tbl(k, int'($urandom_range(0, 16383)) - 8192);
            c_tbl  = (longint'($urandom_range(3, 15)) << FW) |
                     longint'(($urandom_range(0, 1) != 0) ? 65535 : $urandom_range(0, 65535));
            c_step = longint'($urandom_range(1 << 14, 3 << FW));
            c_ofs  = longint'($urandom_range(0, int'(c_tbl)));
            c_amp  = int'($urandom_range(0, 16383));
            c_dc   = int'($urandom_range(0, 16383)) - 8192;
            c_burst = ($urandom_range(0, 3) != 0);
            c_ncyc = int'($urandom_range(0, 2));
            c_nrep = int'($urandom_range(0, 3));
            c_rdly = int'($urandom_range(0, 4));
            settle();
            kick(0);
            check_window($sformatf("random%0d", it), 120);
            finish_run();
        end
    endtask

    initial begin
        bus.tbl_size_i = '0; bus.step_i = '0; bus.ofs_i = '0; bus.amp_i = '0; bus.dc_i = '0;
        bus.burst_i = 1'b0; bus.ncyc_i = '0; bus.nrep_i = '0; bus.rdly_i = '0;
        bus.trig_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
        bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        test_reset();
        test_continuous();
        test_saturation();
        test_burst();
        test_back_to_back();
        test_stop();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
